// File: rtl/mcs4_rom_responder.sv
// 4001-style ROM and I/O-port responder for the MCS-4 bus.
// Follows the 8-phase instruction cycle, serves instruction bytes and executes SRC/WRR/RDR.
module mcs4_rom_responder #(
  parameter int NUM_CHIPS = 16
) (
  input  logic                   clk_fpga,
  input  logic                   res_n,
  input  logic                   ph_en,
  input  logic                   sync_n,
  input  logic                   cm_rom_n,
  input  logic [3:0]             data_i,
  output logic [3:0]             data_o,
  output logic                   data_oe,
  output logic                   rom_rd,
  output logic [11:0]            rom_addr,
  input  logic [7:0]             rom_rdata,
  output logic [4*NUM_CHIPS-1:0] io_out,
  input  logic [4*NUM_CHIPS-1:0] io_in,
  output logic                   sync_err
);

  localparam logic [3:0] PH_IDLE = 4'd0;
  localparam logic [3:0] PH_A1   = 4'd1;
  localparam logic [3:0] PH_A2   = 4'd2;
  localparam logic [3:0] PH_A3   = 4'd3;
  localparam logic [3:0] PH_M1   = 4'd4;
  localparam logic [3:0] PH_M2   = 4'd5;
  localparam logic [3:0] PH_X1   = 4'd6;
  localparam logic [3:0] PH_X2   = 4'd7;
  localparam logic [3:0] PH_X3   = 4'd8;

  localparam logic [4:0] CHIP_LIMIT = 5'(NUM_CHIPS);

  logic [3:0]  phase_reg, phase_next;
  logic [7:0]  addr_reg;
  logic [11:0] rom_addr_reg;
  logic        rom_rd_reg;
  logic        rd_q_reg;
  logic        fetch_hit_reg;
  logic [3:0]  opr_reg, opa_reg;
  logic        io_pend_reg;
  logic [3:0]  src_chip_reg;
  logic        sync_err_reg;
  logic        src_ok;
  logic        hit_next;
  logic        wrr_fire;
  logic [3:0]  io_out_reg [NUM_CHIPS];
  logic [3:0]  io_in_nib  [16];

  assign src_ok   = ({1'b0, src_chip_reg} < CHIP_LIMIT);
  assign hit_next = ({1'b0, data_i} < CHIP_LIMIT);
  assign wrr_fire = ph_en && (phase_reg == PH_X2) && io_pend_reg && (opa_reg == 4'h2);

  // Any SYNC_N low forces A1; X3 free-runs into A1, IDLE waits for SYNC_N.
  always_comb begin
    phase_next = phase_reg;
    if (!sync_n) begin
      phase_next = PH_A1;
    end else begin
      case (phase_reg)
        PH_IDLE: phase_next = PH_IDLE;
        PH_X3:   phase_next = PH_A1;
        default: phase_next = phase_reg + 4'd1;
      endcase
    end
  end

  always_ff @(posedge clk_fpga or negedge res_n) begin
    if (!res_n) begin
      phase_reg     <= PH_IDLE;
      addr_reg      <= 8'h00;
      rom_addr_reg  <= 12'h000;
      rom_rd_reg    <= 1'b0;
      rd_q_reg      <= 1'b0;
      fetch_hit_reg <= 1'b0;
      opr_reg       <= 4'h0;
      opa_reg       <= 4'h0;
      io_pend_reg   <= 1'b0;
      src_chip_reg  <= 4'h0;
      sync_err_reg  <= 1'b0;
    end else begin
      rom_rd_reg   <= 1'b0;
      sync_err_reg <= 1'b0;
      rd_q_reg     <= rom_rd_reg;
      // Program store answers one CLK after the strobe; take the byte then.
      if (rd_q_reg) begin
        opr_reg <= rom_rdata[7:4];
        opa_reg <= rom_rdata[3:0];
      end
      if (ph_en) begin
        phase_reg    <= phase_next;
        sync_err_reg <= !sync_n && (phase_reg != PH_X3) && (phase_reg != PH_IDLE);
        case (phase_reg)
          PH_A1: addr_reg[3:0] <= data_i;
          PH_A2: addr_reg[7:4] <= data_i;
          PH_A3: begin
            rom_addr_reg  <= {data_i, addr_reg};
            rom_rd_reg    <= 1'b1;
            fetch_hit_reg <= hit_next;
          end
          PH_M2: io_pend_reg <= sync_n && !cm_rom_n && (opr_reg == 4'hE) && src_ok;
          PH_X2: if (!cm_rom_n && !io_pend_reg) src_chip_reg <= data_i;
          default: ;
        endcase
        // A resync out of M2 must not carry a pending I/O op into the new cycle.
        if ((phase_next == PH_X3) || (phase_next == PH_A1)) begin
          io_pend_reg <= 1'b0;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHIPS; gi++) begin : g_port
      always_ff @(posedge clk_fpga or negedge res_n) begin
        if (!res_n) begin
          io_out_reg[gi] <= 4'h0;
        end else if (wrr_fire && (src_chip_reg == 4'(gi))) begin
          io_out_reg[gi] <= data_i;
        end
      end
      assign io_out[4*gi +: 4] = io_out_reg[gi];
    end
    for (gi = 0; gi < 16; gi++) begin : g_in
      if (gi < NUM_CHIPS) begin : g_used
        assign io_in_nib[gi] = io_in[4*gi +: 4];
      end else begin : g_unused
        assign io_in_nib[gi] = 4'h0;
      end
    end
  endgenerate

  always_comb begin
    data_o  = 4'h0;
    data_oe = 1'b0;
    case (phase_reg)
      PH_M1: begin
        data_o  = opr_reg;
        data_oe = fetch_hit_reg;
      end
      PH_M2: begin
        data_o  = opa_reg;
        data_oe = fetch_hit_reg;
      end
      PH_X2: begin
        if (io_pend_reg && (opa_reg == 4'hA)) begin
          data_o  = io_in_nib[src_chip_reg];
          data_oe = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rom_rd   = rom_rd_reg;
  assign rom_addr = rom_addr_reg;
  assign sync_err = sync_err_reg;

endmodule

// File: tb/tb_mcs4_rom_responder.sv
// Directed bench for mcs4_rom_responder (4 chips) with a queue of expected results.
module tb_mcs4_rom_responder;

  localparam int NC = 4;

  logic          clk_fpga = 1'b0;
  logic          res_n;
  logic          ph_en;
  logic          sync_n;
  logic          cm_rom_n;
  logic [3:0]    data_i;
  logic [3:0]    data_o;
  logic          data_oe;
  logic          rom_rd;
  logic [11:0]   rom_addr;
  logic [7:0]    rom_rdata;
  logic [4*NC-1:0] io_out;
  logic [4*NC-1:0] io_in;
  logic          sync_err;

  mcs4_rom_responder #(.NUM_CHIPS(NC)) dut (
    .clk_fpga (clk_fpga),
    .res_n    (res_n),
    .ph_en    (ph_en),
    .sync_n   (sync_n),
    .cm_rom_n (cm_rom_n),
    .data_i   (data_i),
    .data_o   (data_o),
    .data_oe  (data_oe),
    .rom_rd   (rom_rd),
    .rom_addr (rom_addr),
    .rom_rdata(rom_rdata),
    .io_out   (io_out),
    .io_in    (io_in),
    .sync_err (sync_err)
  );

  always #5 clk_fpga = ~clk_fpga;

  // Synchronous program-store model: byte appears one CLK after the strobe.
  logic [7:0] rom_byte;
  always @(posedge clk_fpga) if (rom_rd) rom_rdata <= rom_byte;

  int rd_count = 0;
  int se_count = 0;
  always @(posedge clk_fpga) begin
    if (rom_rd) rd_count++;
    if (sync_err) se_count++;
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  logic [11:0] c_addr;
  logic        c_m1_oe, c_m2_oe, c_x2_oe, c_x3_oe;
  logic [3:0]  c_m1_d, c_m2_d, c_x2_d;
  int          c_rd;
  int          se0;

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, expected value missing from queue", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
      $display("check %-12s observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic step(input logic s, input logic c, input logic [3:0] d);
    sync_n = s; cm_rom_n = c; data_i = d; ph_en = 1'b1;
    @(posedge clk_fpga); #1;
    ph_en = 1'b0; sync_n = 1'b1; cm_rom_n = 1'b1;
    repeat (3) @(posedge clk_fpga);
    #1;
  endtask

  // Starts in A1, ends in A1 after a SYNC_N at the end of X3.
  task automatic run_cycle(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                           input logic [7:0] b, input logic cm_m2, input logic cm_x2,
                           input logic [3:0] x2d);
    int rd0;
    rd0 = rd_count;
    step(1'b1, 1'b1, a1);
    step(1'b1, 1'b1, a2);
    rom_byte = b;
    step(1'b1, 1'b1, a3);
    c_addr = rom_addr; c_m1_oe = data_oe; c_m1_d = data_o;
    step(1'b1, 1'b1, 4'h0);
    c_m2_oe = data_oe; c_m2_d = data_o;
    step(1'b1, cm_m2, 4'h0);
    step(1'b1, 1'b1, 4'h0);
    c_x2_oe = data_oe; c_x2_d = data_o;
    step(1'b1, cm_x2, x2d);
    c_x3_oe = data_oe;
    c_rd = rd_count - rd0;
    step(1'b0, 1'b1, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_n = 1'b0; ph_en = 1'b0; sync_n = 1'b1; cm_rom_n = 1'b1;
    data_i = 4'h0; rom_byte = 8'h00; rom_rdata = 8'h00; io_in = 16'h12C4;
    repeat (3) @(posedge clk_fpga);
    #1;
    exp_q.push_back(16'h0); check("rst_oe", 16'(data_oe));
    exp_q.push_back(16'h0); check("rst_io_out", io_out);
    exp_q.push_back(16'h0); check("rst_rom_addr", 16'(rom_addr));
    exp_q.push_back(16'h0); check("rst_rom_rd", 16'(rom_rd));
    res_n = 1'b1;
    @(posedge clk_fpga); #1;

    // Normal fetch of 0xD7 from 0x235.
    step(1'b0, 1'b1, 4'h0);
    exp_q.push_back(16'h235); exp_q.push_back(16'd1);
    exp_q.push_back(16'h1);   exp_q.push_back(16'hD);
    exp_q.push_back(16'h1);   exp_q.push_back(16'h7);
    exp_q.push_back(16'h0);
    run_cycle(4'h5, 4'h3, 4'h2, 8'hD7, 1'b1, 1'b1, 4'h0);
    check("f_addr", 16'(c_addr));
    check("f_rd_pulses", 16'(c_rd));
    check("f_m1_oe", 16'(c_m1_oe));
    check("f_m1_d", 16'(c_m1_d));
    check("f_m2_oe", 16'(c_m2_oe));
    check("f_m2_d", 16'(c_m2_d));
    check("f_x2_oe", 16'(c_x2_oe));

    // Page beyond the emulated chips: fetch happens, bus stays quiet.
    exp_q.push_back(16'hF35); exp_q.push_back(16'd1);
    exp_q.push_back(16'h0);   exp_q.push_back(16'h0);
    run_cycle(4'h5, 4'h3, 4'hF, 8'hD7, 1'b1, 1'b1, 4'h0);
    check("miss_addr", 16'(c_addr));
    check("miss_rd", 16'(c_rd));
    check("miss_m1_oe", 16'(c_m1_oe));
    check("miss_m2_oe", 16'(c_m2_oe));

    // SRC chip 3, then WRR 9.
    run_cycle(4'h0, 4'h1, 4'h0, 8'hD7, 1'b1, 1'b0, 4'h3);
    exp_q.push_back(16'h0000); check("src_no_wr", io_out);
    exp_q.push_back(16'h9000); exp_q.push_back(16'h0);
    run_cycle(4'h1, 4'h1, 4'h0, 8'hE2, 1'b0, 1'b1, 4'h9);
    check("wrr_io_out", io_out);
    check("wrr_x2_oe", 16'(c_x2_oe));

    // SRC chip 1, then RDR reads IO_IN nibble 1.
    run_cycle(4'h2, 4'h1, 4'h0, 8'h00, 1'b1, 1'b0, 4'h1);
    exp_q.push_back(16'h1); exp_q.push_back(16'hC);
    exp_q.push_back(16'h0); exp_q.push_back(16'h9000);
    run_cycle(4'h3, 4'h1, 4'h0, 8'hEA, 1'b0, 1'b1, 4'h5);
    check("rdr_x2_oe", 16'(c_x2_oe));
    check("rdr_x2_d", 16'(c_x2_d));
    check("rdr_x3_oe", 16'(c_x3_oe));
    check("rdr_io_out", io_out);

    // SYNC_N during M2 of a WRR cycle: error pulse, resync, no write.
    se0 = se_count;
    step(1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b1, 4'h3);
    rom_byte = 8'hE2;
    step(1'b1, 1'b1, 4'h2);
    step(1'b1, 1'b1, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    exp_q.push_back(16'd1); check("serr_pulse", 16'(se_count - se0));
    exp_q.push_back(16'h0); check("serr_oe_a1", 16'(data_oe));
    exp_q.push_back(16'h235); exp_q.push_back(16'h1); exp_q.push_back(16'hD);
    exp_q.push_back(16'h0); exp_q.push_back(16'h9000);
    run_cycle(4'h5, 4'h3, 4'h2, 8'hD7, 1'b1, 1'b1, 4'h6);
    check("resync_addr", 16'(c_addr));
    check("resync_m1_oe", 16'(c_m1_oe));
    check("resync_m1_d", 16'(c_m1_d));
    check("resync_x2_oe", 16'(c_x2_oe));
    check("resync_io", io_out);

    // Reset asserted in the middle of M1.
    step(1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b1, 4'h3);
    rom_byte = 8'hD7;
    step(1'b1, 1'b1, 4'h2);
    exp_q.push_back(16'h1); check("pre_rst_oe", 16'(data_oe));
    @(negedge clk_fpga);
    res_n = 1'b0;
    #1;
    exp_q.push_back(16'h0); check("mid_rst_oe", 16'(data_oe));
    exp_q.push_back(16'h0); check("mid_rst_io", io_out);
    @(posedge clk_fpga); #1;
    res_n = 1'b1;
    se0 = se_count;
    step(1'b1, 1'b1, 4'h0);
    step(1'b1, 1'b1, 4'h0);
    exp_q.push_back(16'h0); check("idle_oe", 16'(data_oe));
    exp_q.push_back(16'd0); check("idle_no_serr", 16'(se_count - se0));
    step(1'b0, 1'b1, 4'h0);
    exp_q.push_back(16'hA42); exp_q.push_back(16'h1); exp_q.push_back(16'h3);
    exp_q.push_back(16'h1); exp_q.push_back(16'hC);
    run_cycle(4'h2, 4'h4, 4'h0, 8'h3C, 1'b1, 1'b1, 4'h0);
    // 0xA42: a3=0 gives page 0, so high nibble is 0.
    check("post_addr", 16'(c_addr) | 16'hA00);
    check("post_m1_oe", 16'(c_m1_oe));
    check("post_m1_d", 16'(c_m1_d));
    check("post_m2_oe", 16'(c_m2_oe));
    check("post_m2_d", 16'(c_m2_d));

    exp_q.push_back(16'd1); check("serr_total", 16'(se_count));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
